// File: rtl/sodor_isa_pkg.sv
// Shared RV32I encodings and generator types for the sodor3 stimulus blocks.
// Also holds the xorshift32 step used by the instruction generator.
package sodor_isa_pkg;

   localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
   localparam logic [31:0] NOP        = 32'h0000_0013;
   localparam logic [2:0]  F3_SR      = 3'd5;
   localparam logic [2:0]  F3_SLL     = 3'd1;

   typedef enum logic [1:0] {
      MODE_MIXED = 2'd0,
      MODE_ALU   = 2'd1,
      MODE_LOAD  = 2'd2,
      MODE_NOP   = 2'd3
   } gen_mode_t;

   typedef enum logic [1:0] {
      ST_WARMUP = 2'd0,
      ST_RUN    = 2'd1,
      ST_DONE   = 2'd2
   } gen_state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic        is_load;
   } enc_word_t;

   function automatic logic [31:0] xorshift32(input logic [31:0] x);
      logic [31:0] y;
      y = x ^ (x << 13);
      y = y ^ (y >> 17);
      y = y ^ (y << 5);
      return y;
   endfunction

endpackage

// File: rtl/iltype_field_encoder.sv
// Maps one xorshift32 state to an OP-IMM or load word, shaped by mode.
// Shift immediates are masked so SLLI/SRLI/SRAI are always legal encodings.
module iltype_field_encoder
   import sodor_isa_pkg::*;
(
   input  logic [31:0] s,
   input  gen_mode_t   mode,
   output enc_word_t   word
);

   logic [11:0] imm;
   logic [11:0] alu_imm;
   logic [4:0]  rs1;
   logic [4:0]  rd;
   logic [2:0]  f3;
   logic [2:0]  lf3;
   logic        choice;
   logic [31:0] alu_word;
   logic [31:0] load_word;
   logic        unused_hi;

   // Top state bits carry no field.
   assign unused_hi = ^s[31:27];

   always_comb begin
      imm    = s[11:0];
      rs1    = s[16:12];
      rd     = s[21:17];
      f3     = s[24:22];
      choice = s[25];
      lf3    = {s[26], 2'b00};

      if (f3 == F3_SR)
         alu_imm = imm & 12'h41F;
      else if (f3 == F3_SLL)
         alu_imm = imm & 12'h01F;
      else
         alu_imm = imm;

      alu_word  = {alu_imm, rs1, f3, rd, OPC_OP_IMM};
      load_word = {imm, rs1, lf3, rd, OPC_LOAD};

      word = '{instr: alu_word, is_load: 1'b0};
      case (mode)
         MODE_MIXED: if (!choice) word = '{instr: load_word, is_load: 1'b1};
         MODE_LOAD:  word = '{instr: load_word, is_load: 1'b1};
         MODE_NOP:   word = '{instr: NOP, is_load: 1'b0};
         default:    word = '{instr: alu_word, is_load: 1'b0};
      endcase
   end

endmodule

// File: rtl/riscv_iltype_instr_gen.sv
// Constrained-random OP-IMM/load instruction source feeding sodor3_verif imem.
// Emits a NOP warm-up, then xorshift32-driven words over a valid/ready port.
module riscv_iltype_instr_gen
   import sodor_isa_pkg::*;
#(
   parameter logic [31:0] SEED      = 32'h0000_0001,
   parameter int unsigned NUM_NOPS  = 4,
   parameter int unsigned MAX_INSTR = 0,
   parameter int unsigned CNT_W     = 32
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic             instr_ready,
   output logic             instr_valid,
   output logic [31:0]      instr,
   output logic             instr_is_load,
   output logic [CNT_W-1:0] instr_count,
   output logic             done
);

   // Handshake: a word transfers on instr_valid && instr_ready; while stalled
   // the word is held. A new word is loaded whenever the output register is
   // empty or draining this cycle and enable is high.

   localparam logic [31:0] SEED_INIT = (SEED == 32'd0) ? 32'd1 : SEED;
   localparam logic [31:0] NOPS_LAST = NUM_NOPS - 32'd1;

   gen_state_t  state;
   gen_state_t  state_next;
   logic [31:0] lfsr;
   logic [31:0] s_next;
   logic [31:0] nop_cnt;
   logic [31:0] run_loaded;
   logic        cur_is_run;
   logic        slot;
   logic        fire;
   logic        run_phase;
   logic        run_allowed;
   logic        load_nop;
   logic        load_run;
   logic        last_xfer;
   enc_word_t   enc;

   assign s_next = xorshift32(lfsr);

   iltype_field_encoder u_enc (
      .s    (s_next),
      .mode (gen_mode_t'(mode)),
      .word (enc)
   );

   always_comb begin
      slot        = (!instr_valid || instr_ready) && enable;
      fire        = instr_valid && instr_ready;
      run_phase   = (state == ST_RUN) || ((state == ST_WARMUP) && (NUM_NOPS == 0));
      run_allowed = (MAX_INSTR == 0) || (run_loaded < MAX_INSTR);
      load_nop    = slot && (state == ST_WARMUP) && (NUM_NOPS != 0);
      load_run    = slot && run_phase && run_allowed;
      // cur_is_run marks the held word as random; the warm-up NOPs never count.
      last_xfer   = fire && cur_is_run && (MAX_INSTR != 0) && (run_loaded == MAX_INSTR);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_WARMUP;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_WARMUP: begin
            if (NUM_NOPS == 0) begin
               if (slot) state_next = ST_RUN;
            end else if (load_nop && (nop_cnt == NOPS_LAST)) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN:  if (last_xfer) state_next = ST_DONE;
         ST_DONE: state_next = ST_DONE;
         default: state_next = ST_WARMUP;
      endcase
   end

   always_comb begin
      done = (state == ST_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr          <= SEED_INIT;
         nop_cnt       <= '0;
         run_loaded    <= '0;
         cur_is_run    <= 1'b0;
         instr         <= NOP;
         instr_valid   <= 1'b0;
         instr_is_load <= 1'b0;
         instr_count   <= '0;
      end else begin
         if (fire && cur_is_run)
            instr_count <= instr_count + CNT_W'(1);

         if (load_nop) begin
            instr         <= NOP;
            instr_is_load <= 1'b0;
            instr_valid   <= 1'b1;
            cur_is_run    <= 1'b0;
            nop_cnt       <= nop_cnt + 32'd1;
         end else if (load_run) begin
            instr         <= enc.instr;
            instr_is_load <= enc.is_load;
            instr_valid   <= 1'b1;
            cur_is_run    <= 1'b1;
            lfsr          <= s_next;
            if (MAX_INSTR != 0)
               run_loaded <= run_loaded + 32'd1;
         end else if (slot || fire) begin
            // Drained with nothing to replace it: limit reached or enable low.
            instr_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_riscv_iltype_instr_gen.sv
// Randomized bench for riscv_iltype_instr_gen against a cycle-level behavioural model.
module tb_riscv_iltype_instr_gen;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic        instr_ready = 1'b0;

   logic        instr_valid;
   logic [31:0] instr;
   logic        instr_is_load;
   logic [31:0] instr_count;
   logic        done;

   logic        instr_valid_m;
   logic [31:0] instr_m;
   logic        instr_is_load_m;
   logic [31:0] instr_count_m;
   logic        done_m;

   int checks = 0;
   int failures = 0;

   // model of the unlimited instance
   logic        m_valid;
   logic        m_is_load;
   logic [31:0] m_word;
   logic [31:0] m_count;
   logic [31:0] m_lfsr;
   int          m_nops_left;
   logic        m_cur_run;

   // transfers seen at the most recent edge
   logic        xfer;
   logic        xfer_load;
   logic [31:0] xfer_word;
   logic        xfer_m;
   logic [31:0] xfer_word_m;

   logic [31:0] got_q[$];
   logic        got_load_q[$];
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   riscv_iltype_instr_gen #(
      .SEED(32'h1), .NUM_NOPS(4), .MAX_INSTR(0), .CNT_W(32)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode),
      .instr_ready(instr_ready), .instr_valid(instr_valid), .instr(instr),
      .instr_is_load(instr_is_load), .instr_count(instr_count), .done(done)
   );

   riscv_iltype_instr_gen #(
      .SEED(32'h1), .NUM_NOPS(4), .MAX_INSTR(3), .CNT_W(32)
   ) dut_max (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode),
      .instr_ready(instr_ready), .instr_valid(instr_valid_m), .instr(instr_m),
      .instr_is_load(instr_is_load_m), .instr_count(instr_count_m), .done(done_m)
   );

   function automatic logic [31:0] ref_xorshift(input logic [31:0] x);
      logic [31:0] v;
      v = x;
      v = v ^ (v * 32'd8192);
      v = v ^ (v / 32'd131072);
      v = v ^ (v * 32'd32);
      return v;
   endfunction

   task automatic ref_encode(input logic [31:0] s, input int md,
                             output logic [31:0] word, output logic ld);
      int unsigned imm, rs1, rd, f3, choice, b26;
      bit alu;
      imm    = s % 4096;
      rs1    = (s / 4096) % 32;
      rd     = (s / 131072) % 32;
      f3     = (s / 4194304) % 8;
      choice = (s / 33554432) % 2;
      b26    = (s / 67108864) % 2;
      alu    = (md == 1) || ((md == 0) && (choice == 1));
      if (md == 3) begin
         word = 32'h13;
         ld   = 1'b0;
      end else if (alu) begin
         if (f3 == 5) imm = imm & 32'h41F;
         else if (f3 == 1) imm = imm % 32;
         word = imm * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + 19;
         ld   = 1'b0;
      end else begin
         word = imm * 1048576 + rs1 * 32768 + b26 * 4 * 4096 + rd * 128 + 3;
         ld   = 1'b1;
      end
   endtask

   task automatic model_reset();
      m_valid     = 1'b0;
      m_is_load   = 1'b0;
      m_word      = 32'h13;
      m_count     = 32'd0;
      m_lfsr      = 32'd1;
      m_nops_left = 4;
      m_cur_run   = 1'b0;
   endtask

   task automatic model_edge();
      bit fire_e, slot_e;
      fire_e = m_valid && instr_ready;
      slot_e = (!m_valid || instr_ready) && enable;
      if (fire_e && m_cur_run) m_count = m_count + 32'd1;
      if (slot_e) begin
         if (m_nops_left > 0) begin
            m_word      = 32'h13;
            m_is_load   = 1'b0;
            m_cur_run   = 1'b0;
            m_nops_left = m_nops_left - 1;
         end else begin
            m_lfsr    = ref_xorshift(m_lfsr);
            ref_encode(m_lfsr, int'(mode), m_word, m_is_load);
            m_cur_run = 1'b1;
         end
         m_valid = 1'b1;
      end else if (fire_e) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic tick();
      xfer        = instr_valid && instr_ready;
      xfer_word   = instr;
      xfer_load   = instr_is_load;
      xfer_m      = instr_valid_m && instr_ready;
      xfer_word_m = instr_m;
      if (reset) model_reset();
      else model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; instr_ready = 1'b0; mode = 2'd0;
      tick(); tick();
      checks++;
      if (instr !== 32'h13) begin failures++; $display("FAIL reset_instr got=%h exp=%h", instr, 32'h13); end
      checks++;
      if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
      checks++;
      if (instr_is_load !== 1'b0) begin failures++; $display("FAIL reset_is_load got=%b exp=0", instr_is_load); end
      checks++;
      if (instr_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", instr_count); end
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++;
      if ({instr_valid_m, done_m, instr_m} !== {1'b0, 1'b0, 32'h13}) begin
         failures++; $display("FAIL reset_max got=%b%b %h exp=00 00000013", instr_valid_m, done_m, instr_m);
      end
   endtask

   task automatic test_first_words(input string tag);
      reset = 1'b0; enable = 1'b1; instr_ready = 1'b1; mode = 2'd0;
      got_q.delete(); got_load_q.delete();
      repeat (6) begin
         tick();
         if (xfer) begin got_q.push_back(xfer_word); got_load_q.push_back(xfer_load); end
         checks++;
         if ({instr_valid, instr_is_load, instr, instr_count, done} !== {m_valid, m_is_load, m_word, m_count, 1'b0}) begin
            failures++;
            $display("FAIL %s_track t=%0t got=%b%b %h %0d %b exp=%b%b %h %0d 0", tag, $time,
                     instr_valid, instr_is_load, instr, instr_count, done, m_valid, m_is_load, m_word, m_count);
         end
      end
      checks++;
      if (got_q.size() != 5) begin
         failures++; $display("FAIL %s_xfer_count got=%0d exp=5", tag, got_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_q[i] !== 32'h13) begin failures++; $display("FAIL %s_nop%0d got=%h exp=00000013", tag, i, got_q[i]); end
         end
         checks++;
         if (got_q[4] !== 32'h02110103) begin failures++; $display("FAIL %s_first_word got=%h exp=02110103", tag, got_q[4]); end
         checks++;
         if (got_load_q[4] !== 1'b1) begin failures++; $display("FAIL %s_first_is_load got=%b exp=1", tag, got_load_q[4]); end
      end
      checks++;
      if (instr_count !== 32'd1) begin failures++; $display("FAIL %s_count got=%0d exp=1", tag, instr_count); end
   endtask

   task automatic test_stall();
      logic [31:0] held_word;
      logic [31:0] held_count;
      instr_ready = 1'b0;
      held_word  = m_word;
      held_count = m_count;
      repeat (5) begin
         tick();
         checks++;
         if ({instr_valid, instr} !== {1'b1, held_word}) begin
            failures++; $display("FAIL stall_hold got=%b %h exp=1 %h", instr_valid, instr, held_word);
         end
         checks++;
         if (instr_count !== held_count) begin
            failures++; $display("FAIL stall_count got=%0d exp=%0d", instr_count, held_count);
         end
      end
      instr_ready = 1'b1;
      repeat (6) begin
         tick();
         checks++;
         if ({instr_valid, instr_is_load, instr, instr_count} !== {m_valid, m_is_load, m_word, m_count}) begin
            failures++;
            $display("FAIL stall_resume got=%b%b %h %0d exp=%b%b %h %0d", instr_valid, instr_is_load, instr,
                     instr_count, m_valid, m_is_load, m_word, m_count);
         end
      end
   endtask

   task automatic test_mode_words(input logic [1:0] md, input int n_words, input string tag);
      int nx;
      int cyc;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [11:0] imm;
      mode = md;
      nx = 0;
      cyc = 0;
      while (nx < n_words && cyc < 6000) begin
         instr_ready = ($urandom_range(0, 3) != 0);
         enable      = ($urandom_range(0, 7) != 0);
         tick();
         cyc++;
         checks++;
         if ({instr_valid, instr_is_load, instr, instr_count, done} !== {m_valid, m_is_load, m_word, m_count, 1'b0}) begin
            failures++;
            $display("FAIL %s_track t=%0t got=%b%b %h %0d %b exp=%b%b %h %0d 0", tag, $time,
                     instr_valid, instr_is_load, instr, instr_count, done, m_valid, m_is_load, m_word, m_count);
         end
         if (xfer) begin
            nx++;
            // the first word out was loaded under the previous mode
            if (nx > 1) begin
               opc = xfer_word[6:0];
               f3  = xfer_word[14:12];
               imm = xfer_word[31:20];
               if (md == 2'd1) begin
                  checks++;
                  if (opc !== 7'h13 || xfer_load !== 1'b0) begin
                     failures++; $display("FAIL %s_opcode got=%h load=%b exp=13 load=0", tag, opc, xfer_load);
                  end
                  if (f3 == 3'd5) begin
                     checks++;
                     if ((imm & 12'hBE0) !== 12'h000) begin failures++; $display("FAIL %s_sr_imm got=%h", tag, imm); end
                  end
                  if (f3 == 3'd1) begin
                     checks++;
                     if (imm[11:5] !== 7'h00) begin failures++; $display("FAIL %s_sll_imm got=%h", tag, imm); end
                  end
               end else if (md == 2'd2) begin
                  checks++;
                  if (opc !== 7'h03 || !(f3 == 3'd0 || f3 == 3'd4) || xfer_load !== 1'b1) begin
                     failures++; $display("FAIL %s_load_word got=%h f3=%0d load=%b exp=03 f3=0/4 load=1", tag, opc, f3, xfer_load);
                  end
               end else begin
                  checks++;
                  if (xfer_word !== 32'h13) begin failures++; $display("FAIL %s_nop_word got=%h exp=00000013", tag, xfer_word); end
               end
            end
         end
      end
      checks++;
      if (nx < n_words) begin failures++; $display("FAIL %s_timeout got=%0d exp=%0d", tag, nx, n_words); end
      enable = 1'b1;
      instr_ready = 1'b1;
   endtask

   task automatic test_max_instr();
      logic [31:0] lf;
      logic [31:0] w;
      logic        l;
      logic [31:0] got_m[$];
      reset = 1'b1; tick(); tick();
      reset = 1'b0; enable = 1'b1; instr_ready = 1'b1; mode = 2'd0;
      exp_q.delete();
      repeat (4) exp_q.push_back(32'h13);
      lf = 32'd1;
      repeat (3) begin
         lf = ref_xorshift(lf);
         ref_encode(lf, 0, w, l);
         exp_q.push_back(w);
      end
      repeat (30) begin
         tick();
         if (xfer_m) got_m.push_back(xfer_word_m);
      end
      checks++;
      if (got_m.size() != 7) begin
         failures++; $display("FAIL max_xfer_count got=%0d exp=7", got_m.size());
      end else begin
         for (int i = 0; i < 7; i++) begin
            checks++;
            if (got_m[i] !== exp_q[i]) begin failures++; $display("FAIL max_word%0d got=%h exp=%h", i, got_m[i], exp_q[i]); end
         end
      end
      checks++;
      if (instr_count_m !== 32'd3) begin failures++; $display("FAIL max_count got=%0d exp=3", instr_count_m); end
      repeat (20) begin
         instr_ready = ($urandom_range(0, 1) != 0);
         tick();
         checks++;
         if ({done_m, instr_valid_m} !== 2'b10) begin
            failures++; $display("FAIL max_done_hold got=%b%b exp=10", done_m, instr_valid_m);
         end
      end
      instr_ready = 1'b1;
   endtask

   task automatic test_reset_mid_stall();
      mode = 2'd0; enable = 1'b1; instr_ready = 1'b1;
      repeat (4) tick();
      instr_ready = 1'b0;
      tick(); tick();
      checks++;
      if (instr_valid !== 1'b1) begin failures++; $display("FAIL midreset_pre_valid got=%b exp=1", instr_valid); end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({instr, instr_valid, instr_is_load, instr_count} !== {32'h13, 1'b0, 1'b0, 32'd0}) begin
         failures++;
         $display("FAIL midreset_outputs got=%h %b %b %0d exp=00000013 0 0 0", instr, instr_valid, instr_is_load, instr_count);
      end
      model_reset();
      tick();
      test_first_words("midreset");
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      test_reset();
      test_first_words("warmup");
      test_stall();
      test_mode_words(2'd1, 1000, "alu");
      test_mode_words(2'd2, 1000, "load");
      test_mode_words(2'd3, 60, "nop");
      test_max_instr();
      test_reset_mid_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
